mem_stage: RTL and testbench

Memory-access stage of the 6-stage MIPS pipeline, directly downstream of the EX/MEM pipeline register. It consumes the registered EX/MEM bundle, performs loads and stores against an internal word-organised data memory with byte/halfword lanes, and produces the registered MEM/WB bundle for the write-back stage. It also detects misaligned accesses, and supports pipeline stall and flush.

---
 rtl/mem_stage_if.sv | 41 ++++
 rtl/mem_stage.sv | 164 ++++++++++++++++
 tb/tb_mem_stage.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// EX/MEM input bundle and MEM/WB output bundle of the memory-access stage.
interface mem_stage_if;
   // pipeline control
   logic        stall;
   logic        flush;
   // EX/MEM bundle
   logic [5:0]  opcodeo_ex;
   logic [4:0]  rto_ex;
   logic [4:0]  rdo_ex;
   logic [31:0] resulto_ex;
   logic [31:0] rdo2_ex;
   logic        MemtoRego_ex;
   logic        RegWriteo_ex;
   logic        MemReado_ex;
   logic        MemWriteo_ex;
   logic        Jumpo_ex;
   // MEM/WB bundle
   logic [31:0] resulto_mem;
   logic [31:0] memdatao_mem;
   logic [31:0] wbdatao_mem;
   logic [4:0]  wregaddro_mem;
   logic        RegWriteo_mem;
   logic        MemtoRego_mem;
   logic        misaligno_mem;

   // upstream side: drives the EX/MEM bundle, observes MEM/WB
   modport master (
      output stall, flush, opcodeo_ex, rto_ex, rdo_ex, resulto_ex, rdo2_ex,
             MemtoRego_ex, RegWriteo_ex, MemReado_ex, MemWriteo_ex, Jumpo_ex,
      input  resulto_mem, memdatao_mem, wbdatao_mem, wregaddro_mem,
             RegWriteo_mem, MemtoRego_mem, misaligno_mem
   );

   // the stage itself
   modport slave (
      input  stall, flush, opcodeo_ex, rto_ex, rdo_ex, resulto_ex, rdo2_ex,
             MemtoRego_ex, RegWriteo_ex, MemReado_ex, MemWriteo_ex, Jumpo_ex,
      output resulto_mem, memdatao_mem, wbdatao_mem, wregaddro_mem,
             RegWriteo_mem, MemtoRego_mem, misaligno_mem
   );
endinterface

// File: rtl/mem_stage.sv
// MIPS memory-access stage: word-organised data memory with byte/halfword lanes,
// misalignment detection, and the registered MEM/WB bundle with stall/flush.
module mem_stage #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = 8
) (
   input logic       clk,
   input logic       rst,
   mem_stage_if.slave bus
);

   localparam logic [5:0] OpLb  = 6'h20;
   localparam logic [5:0] OpLh  = 6'h21;
   localparam logic [5:0] OpLbu = 6'h24;
   localparam logic [5:0] OpLhu = 6'h25;
   localparam logic [5:0] OpSb  = 6'h28;
   localparam logic [5:0] OpSh  = 6'h29;

   typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;

   logic [31:0]   mem_q [DEPTH];

   logic [AW-1:0] word_idx;
   logic [1:0]    lane;
   logic [31:0]   rd_word;
   size_e         acc_size;
   logic          mem_access;
   logic          misaligned;
   logic [7:0]    ld_byte;
   logic [15:0]   ld_half;
   logic [31:0]   ld_data;
   logic [31:0]   st_data;
   logic [3:0]    st_be;
   logic [31:0]   merged_word;
   logic          mem_we;

   logic [31:0]   result_d, result_q;
   logic [31:0]   memdata_d, memdata_q;
   logic [4:0]    wregaddr_d, wregaddr_q;
   logic          regwrite_d, regwrite_q;
   logic          memtoreg_d, memtoreg_q;
   logic          misalign_d, misalign_q;

   // upper address bits are dropped so the memory wraps modulo 4*DEPTH
   assign word_idx   = bus.resulto_ex[AW+1:2];
   assign lane       = bus.resulto_ex[1:0];
   assign rd_word    = mem_q[word_idx];
   assign mem_access = bus.MemReado_ex | bus.MemWriteo_ex;

   // access size: store decoding wins whenever a store is present
   always_comb begin
      acc_size = SzWord;
      if (bus.MemWriteo_ex) begin
         case (bus.opcodeo_ex)
            OpSh:    acc_size = SzHalf;
            OpSb:    acc_size = SzByte;
            default: acc_size = SzWord;
         endcase
      end else begin
         case (bus.opcodeo_ex)
            OpLh, OpLhu: acc_size = SzHalf;
            OpLb, OpLbu: acc_size = SzByte;
            default:     acc_size = SzWord;
         endcase
      end
   end

   assign misaligned = mem_access & (((acc_size == SzWord) & (lane != 2'b00)) |
                                     ((acc_size == SzHalf) & lane[0]));

   // load lane selection and sign/zero extension
   always_comb begin
      ld_byte = rd_word[{lane, 3'b000} +: 8];
      ld_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
      case (acc_size)
         SzByte:  ld_data = (bus.opcodeo_ex == OpLb) ? {{24{ld_byte[7]}}, ld_byte}
                                                     : {24'h0, ld_byte};
         SzHalf:  ld_data = (bus.opcodeo_ex == OpLh) ? {{16{ld_half[15]}}, ld_half}
                                                     : {16'h0, ld_half};
         default: ld_data = rd_word;
      endcase
   end

   // store data replication, byte enables and read-modify-write merge
   always_comb begin
      case (acc_size)
         SzByte: begin
            st_data = {4{bus.rdo2_ex[7:0]}};
            st_be   = 4'b0001 << lane;
         end
         SzHalf: begin
            st_data = {2{bus.rdo2_ex[15:0]}};
            st_be   = lane[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            st_data = bus.rdo2_ex;
            st_be   = 4'b1111;
         end
      endcase
      for (int b = 0; b < 4; b++) begin
         merged_word[8*b +: 8] = st_be[b] ? st_data[8*b +: 8] : rd_word[8*b +: 8];
      end
   end

   assign mem_we = rst & ~bus.flush & ~bus.stall & bus.MemWriteo_ex & ~misaligned;

   // data memory write port; contents survive reset
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[word_idx] <= merged_word;
      end
   end

   // MEM/WB next state: flush clears control bits, stall holds everything
   always_comb begin
      result_d   = result_q;
      memdata_d  = memdata_q;
      wregaddr_d = wregaddr_q;
      regwrite_d = regwrite_q;
      memtoreg_d = memtoreg_q;
      misalign_d = misalign_q;
      if (bus.flush) begin
         regwrite_d = 1'b0;
         memtoreg_d = 1'b0;
         misalign_d = 1'b0;
      end else if (!bus.stall) begin
         result_d   = bus.resulto_ex;
         // a simultaneous store or a misaligned access returns no load data
         memdata_d  = (bus.MemReado_ex & ~bus.MemWriteo_ex & ~misaligned) ? ld_data : 32'h0;
         wregaddr_d = (bus.opcodeo_ex == 6'h00) ? bus.rdo_ex : bus.rto_ex;
         regwrite_d = bus.RegWriteo_ex & ~bus.Jumpo_ex & ~misaligned;
         memtoreg_d = bus.MemtoRego_ex;
         misalign_d = misaligned;
      end
   end

   // MEM/WB pipeline register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         result_q   <= 32'h0;
         memdata_q  <= 32'h0;
         wregaddr_q <= 5'h0;
         regwrite_q <= 1'b0;
         memtoreg_q <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         result_q   <= result_d;
         memdata_q  <= memdata_d;
         wregaddr_q <= wregaddr_d;
         regwrite_q <= regwrite_d;
         memtoreg_q <= memtoreg_d;
         misalign_q <= misalign_d;
      end
   end

   assign bus.resulto_mem   = result_q;
   assign bus.memdatao_mem  = memdata_q;
   assign bus.wbdatao_mem   = memtoreg_q ? memdata_q : result_q;
   assign bus.wregaddro_mem = wregaddr_q;
   assign bus.RegWriteo_mem = regwrite_q;
   assign bus.MemtoRego_mem = memtoreg_q;
   assign bus.misaligno_mem = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic
// checked against a byte-addressed reference memory model.
module tb_mem_stage;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   passed = 0;

   mem_stage_if bus ();

   mem_stage #(.DEPTH(256), .AW(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // reference model: 1024-byte little-endian memory plus expected MEM/WB fields
   logic [7:0]  mem_m [1024];
   logic [31:0] exp_result, exp_memdata;
   logic [4:0]  exp_wreg;
   logic        exp_rw, exp_m2r, exp_mis;
   bit          exp_dc;  // data fields don't-care after a flush

   function automatic logic [31:0] model_word(input int idx);
      return {mem_m[4*idx+3], mem_m[4*idx+2], mem_m[4*idx+1], mem_m[4*idx]};
   endfunction

   task automatic model_step();
      int          a, sz;
      bit          ld, st, mis;
      logic [5:0]  op;
      logic [31:0] v, d;
      if (!rst) begin
         exp_result = 0; exp_memdata = 0; exp_wreg = 0;
         exp_rw = 0; exp_m2r = 0; exp_mis = 0; exp_dc = 0;
      end else if (bus.flush) begin
         exp_rw = 0; exp_m2r = 0; exp_mis = 0; exp_dc = 1;
      end else if (!bus.stall) begin
         op = bus.opcodeo_ex;
         ld = bus.MemReado_ex;
         st = bus.MemWriteo_ex;
         if (st) sz = (op == 6'h29) ? 2 : (op == 6'h28) ? 1 : 4;
         else    sz = (op == 6'h21 || op == 6'h25) ? 2 : (op == 6'h20 || op == 6'h24) ? 1 : 4;
         a   = int'(bus.resulto_ex[9:0]);
         mis = (ld || st) && (a % sz != 0);
         v   = 0;
         if (ld && !st && !mis) begin
            for (int k = 0; k < sz; k++) v = v | (32'(mem_m[a+k]) << (8*k));
            if (sz == 2 && op == 6'h21 && v[15]) v = v | 32'hFFFF0000;
            if (sz == 1 && op == 6'h20 && v[7])  v = v | 32'hFFFFFF00;
         end
         if (st && !mis) begin
            d = bus.rdo2_ex;
            for (int k = 0; k < sz; k++) mem_m[a+k] = d[8*k +: 8];
         end
         exp_result  = bus.resulto_ex;
         exp_memdata = v;
         exp_wreg    = (op == 0) ? bus.rdo_ex : bus.rto_ex;
         exp_rw      = bus.RegWriteo_ex && !bus.Jumpo_ex && !mis;
         exp_m2r     = bus.MemtoRego_ex;
         exp_mis     = mis;
         exp_dc      = 0;
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [4:0] rt, input logic m2r, input logic rw,
                        input logic mr, input logic mw);
      bus.stall        = 1'b0;
      bus.flush        = 1'b0;
      bus.opcodeo_ex   = op;
      bus.resulto_ex   = addr;
      bus.rdo2_ex      = data;
      bus.rto_ex       = rt;
      bus.rdo_ex       = 5'd17;
      bus.MemtoRego_ex = m2r;
      bus.RegWriteo_ex = rw;
      bus.MemReado_ex  = mr;
      bus.MemWriteo_ex = mw;
      bus.Jumpo_ex     = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] w4;
      w4 = model_word(4);
      rst = 1'b0;
      drive(6'h2B, 32'h10, 32'hDEADBEEF, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
      cycle();
      cycle();
      total++;
      if ({bus.resulto_mem, bus.memdatao_mem, bus.wbdatao_mem, bus.wregaddro_mem,
           bus.RegWriteo_mem, bus.MemtoRego_mem, bus.misaligno_mem} !== '0)
         $display("FAIL reset_outputs got res=%h md=%h wb=%h wr=%h rw=%b m2r=%b mis=%b want all 0",
                  bus.resulto_mem, bus.memdatao_mem, bus.wbdatao_mem, bus.wregaddro_mem,
                  bus.RegWriteo_mem, bus.MemtoRego_mem, bus.misaligno_mem);
      else passed++;
      rst = 1'b1;
      drive(6'h00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle();
      total++;
      if (dut.mem_q[4] !== w4)
         $display("FAIL reset_no_store got %h want %h", dut.mem_q[4], w4);
      else passed++;
   endtask

   task automatic test_store_load();
      drive(6'h2B, 32'h20, 32'h11223344, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle();
      drive(6'h23, 32'h20, 32'h0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
      cycle();
      total++;
      if (bus.wbdatao_mem !== 32'h11223344)
         $display("FAIL st_ld_data got %h want %h", bus.wbdatao_mem, 32'h11223344);
      else passed++;
      total++;
      if (bus.wregaddro_mem !== 5'd5 || bus.RegWriteo_mem !== 1'b1)
         $display("FAIL st_ld_ctrl got wr=%0d rw=%b want wr=5 rw=1",
                  bus.wregaddro_mem, bus.RegWriteo_mem);
      else passed++;
   endtask

   task automatic test_subword();
      drive(6'h28, 32'h21, 32'h000000AA, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle();
      drive(6'h23, 32'h20, 32'h0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
      cycle();
      total++;
      if (bus.wbdatao_mem !== 32'h1122AA44)
         $display("FAIL sb_lw got %h want %h", bus.wbdatao_mem, 32'h1122AA44);
      else passed++;
      drive(6'h20, 32'h21, 32'h0, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0);
      cycle();
      total++;
      if (bus.wbdatao_mem !== 32'hFFFFFFAA)
         $display("FAIL lb got %h want %h", bus.wbdatao_mem, 32'hFFFFFFAA);
      else passed++;
      drive(6'h24, 32'h21, 32'h0, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0);
      cycle();
      total++;
      if (bus.wbdatao_mem !== 32'h000000AA)
         $display("FAIL lbu got %h want %h", bus.wbdatao_mem, 32'h000000AA);
      else passed++;
      drive(6'h29, 32'h22, 32'h00008001, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle();
      drive(6'h21, 32'h22, 32'h0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
      cycle();
      total++;
      if (bus.wbdatao_mem !== 32'hFFFF8001)
         $display("FAIL sh_lh got %h want %h", bus.wbdatao_mem, 32'hFFFF8001);
      else passed++;
   endtask

   task automatic test_misaligned();
      drive(6'h23, 32'h22, 32'h0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0);
      cycle();
      total++;
      if (bus.misaligno_mem !== 1'b1 || bus.RegWriteo_mem !== 1'b0 || bus.memdatao_mem !== 0)
         $display("FAIL mis_lw got mis=%b rw=%b md=%h want mis=1 rw=0 md=0",
                  bus.misaligno_mem, bus.RegWriteo_mem, bus.memdatao_mem);
      else passed++;
      drive(6'h29, 32'h23, 32'h00005555, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle();
      total++;
      if (dut.mem_q[8] !== 32'h8001AA44)
         $display("FAIL mis_sh got %h want %h", dut.mem_q[8], 32'h8001AA44);
      else passed++;
   endtask

   task automatic test_stall();
      logic [31:0] w16, wb0;
      w16 = model_word(16);
      wb0 = exp_m2r ? exp_memdata : exp_result;
      drive(6'h2B, 32'h40, 32'h0BADF00D, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1);
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         total++;
         if (bus.wbdatao_mem !== wb0 || bus.misaligno_mem !== exp_mis ||
             bus.RegWriteo_mem !== exp_rw || dut.mem_q[16] !== w16)
            $display("FAIL stall_hold cyc%0d got wb=%h mis=%b rw=%b mem=%h want wb=%h mis=%b rw=%b mem=%h",
                     i, bus.wbdatao_mem, bus.misaligno_mem, bus.RegWriteo_mem, dut.mem_q[16],
                     wb0, exp_mis, exp_rw, w16);
         else passed++;
      end
      bus.stall = 1'b0;
      cycle();
      total++;
      if (dut.mem_q[16] !== 32'h0BADF00D || bus.resulto_mem !== 32'h40)
         $display("FAIL stall_release got mem=%h res=%h want mem=0badf00d res=40",
                  dut.mem_q[16], bus.resulto_mem);
      else passed++;
   endtask

   task automatic test_flush();
      drive(6'h00, 32'h1234, 32'h0, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0);
      bus.flush = 1'b1;
      cycle();
      total++;
      if (bus.RegWriteo_mem !== 1'b0 || bus.MemtoRego_mem !== 1'b0 || bus.misaligno_mem !== 1'b0)
         $display("FAIL flush got rw=%b m2r=%b mis=%b want 0 0 0",
                  bus.RegWriteo_mem, bus.MemtoRego_mem, bus.misaligno_mem);
      else passed++;
      drive(6'h00, 32'h1234, 32'h0, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0);
      cycle();
      total++;
      if (bus.RegWriteo_mem !== 1'b1 || bus.wregaddro_mem !== 5'd17)
         $display("FAIL rtype got rw=%b wr=%0d want rw=1 wr=17",
                  bus.RegWriteo_mem, bus.wregaddro_mem);
      else passed++;
   endtask

   task automatic test_wrap();
      drive(6'h2B, 32'h400, 32'hCAFEF00D, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle();
      drive(6'h23, 32'h000, 32'h0, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0);
      cycle();
      total++;
      if (bus.wbdatao_mem !== 32'hCAFEF00D)
         $display("FAIL wrap got %h want %h", bus.wbdatao_mem, 32'hCAFEF00D);
      else passed++;
   endtask

   task automatic test_random();
      logic [5:0] ops [10];
      int         idx;
      ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h00, 6'h3F};
      for (int n = 0; n < 400; n++) begin
         rst              = ($urandom_range(0, 99) >= 3);
         bus.stall        = ($urandom_range(0, 99) < 10);
         bus.flush        = ($urandom_range(0, 99) < 8);
         bus.opcodeo_ex   = ($urandom_range(0, 9) == 9) ? 6'($urandom) : ops[$urandom_range(0, 8)];
         bus.resulto_ex   = ($urandom_range(0, 1) == 0) ? ($urandom & 32'hFFFF_F83C)
                                                        : ($urandom & 32'hFFFF_F83F);
         bus.rdo2_ex      = $urandom;
         bus.rto_ex       = 5'($urandom);
         bus.rdo_ex       = 5'($urandom);
         bus.MemtoRego_ex = 1'($urandom);
         bus.RegWriteo_ex = 1'($urandom);
         bus.MemReado_ex  = 1'($urandom);
         bus.MemWriteo_ex = ($urandom_range(0, 2) == 0);
         bus.Jumpo_ex     = ($urandom_range(0, 7) == 0);
         idx              = int'(bus.resulto_ex[9:2]);
         cycle();
         total++;
         if (bus.RegWriteo_mem !== exp_rw || bus.MemtoRego_mem !== exp_m2r ||
             bus.misaligno_mem !== exp_mis)
            $display("FAIL rnd_ctrl n=%0d got rw=%b m2r=%b mis=%b want rw=%b m2r=%b mis=%b", n,
                     bus.RegWriteo_mem, bus.MemtoRego_mem, bus.misaligno_mem,
                     exp_rw, exp_m2r, exp_mis);
         else passed++;
         if (!exp_dc) begin
            total++;
            if (bus.resulto_mem !== exp_result || bus.memdatao_mem !== exp_memdata ||
                bus.wregaddro_mem !== exp_wreg ||
                bus.wbdatao_mem !== (exp_m2r ? exp_memdata : exp_result))
               $display("FAIL rnd_data n=%0d got res=%h md=%h wr=%0d wb=%h want res=%h md=%h wr=%0d",
                        n, bus.resulto_mem, bus.memdatao_mem, bus.wregaddro_mem,
                        bus.wbdatao_mem, exp_result, exp_memdata, exp_wreg);
            else passed++;
         end
         total++;
         if (dut.mem_q[idx] !== model_word(idx))
            $display("FAIL rnd_mem n=%0d word %0d got %h want %h", n, idx,
                     dut.mem_q[idx], model_word(idx));
         else passed++;
      end
      rst = 1'b1;
   endtask

   initial begin
      logic [31:0] w;
      for (int i = 0; i < 256; i++) begin
         w = $urandom;
         dut.mem_q[i] = w;
         for (int k = 0; k < 4; k++) mem_m[4*i+k] = w[8*k +: 8];
      end
      exp_result = 0; exp_memdata = 0; exp_wreg = 0;
      exp_rw = 0; exp_m2r = 0; exp_mis = 0; exp_dc = 0;
      drive(6'h00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      test_reset();
      test_store_load();
      test_subword();
      test_misaligned();
      test_stall();
      test_flush();
      test_wrap();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
